// File: rtl/rr_arb_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter.
// Client count, index width, FSM state encoding and the default hold limit.
package rr_arb_8_pkg;

    localparam int N_CLIENTS    = 8;
    localparam int IDX_W        = 3;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/deco_3_8.sv
// Binary 3-to-8 decoder.
// Produces a one-hot output for the index on in_i.
module deco_3_8 (
    input  logic [2:0] in_i,
    output logic [7:0] out_o
);

    always_comb begin
        out_o       = '0;
        out_o[in_i] = 1'b1;
    end

endmodule

// File: rtl/rr_arb_8.sv
// Round-robin arbiter for eight requesters. It holds each grant until the holder
// releases it or the hold limit expires, and then rotates priority past that holder.
//
// state | meaning
// IDLE  | no grant active; sample req and pick the next winner from ptr
// BUSY  | grant active; wait for done, req drop or hold limit
module rr_arb_8
    import rr_arb_8_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_CLIENTS-1:0] req_i,
    input  logic                 done_i,
    output logic [N_CLIENTS-1:0] gnt_o,
    output logic [IDX_W-1:0]     gnt_idx_o,
    output logic                 gnt_valid_o,
    output logic                 timeout_o
);

    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;
    logic [IDX_W-1:0]     winner;
    logic [N_CLIENTS-1:0] dec_out;

    // First set request at or after ptr, wrapping modulo N_CLIENTS.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_CLIENTS-1:0] req,
                                                 input logic [IDX_W-1:0]     ptr);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            cand = ptr + IDX_W'(i);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign winner = rr_pick(req_i, ptr_q);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    idx_d   = winner;
                    ptr_d   = winner + IDX_W'(1);
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // A release in the last hold cycle wins over the timeout.
                if (done_i || !req_i[idx_q]) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(MAX_HOLD - 1)) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    deco_3_8 u_deco (
        .in_i  (idx_q),
        .out_o (dec_out)
    );

    assign gnt_valid_o = (state_q == BUSY);
    assign gnt_idx_o   = idx_q;
    assign gnt_o       = dec_out & {N_CLIENTS{gnt_valid_o}};
    assign timeout_o   = timeout_q;

endmodule

// File: doc/rr_arb_8.md
# rr_arb_8

Round-robin arbiter and grant sequencer that shares one resource among eight requesters. It picks one requester at a time, holds the grant until that requester releases it or a hold limit expires, and then rotates priority. The registered 3-bit winner index drives the team's existing 3-to-8 decoder to form the one-hot grant bus. It sits between requester clients and any shared 8-way-selected resource, such as a demux, a bank select or a bus.

## Interface
- MAX_HOLD, default 16: maximum number of cycles a grant stays visible; must be ≥1.
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  8  request per client; level-sensitive; bit i is client i.
- done  in  1  release strobe from the current holder; ignored when gnt_valid=0.
- gnt  out  8  one-hot grant; all zero when gnt_valid=0.
- gnt_idx  out  3  binary index of the current holder.
- gnt_valid  out  1  a grant is active.
- timeout  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- States: IDLE, BUSY.
- Reset (async, while rst_n=0):
  - state=IDLE; gnt=0; gnt_idx=0; gnt_valid=0; timeout=0.
  - Rotation pointer ptr=0; hold counter cnt=0.
- IDLE:
  - If req≠0, select the first set bit scanning ptr, ptr+1, … modulo 8.
  - Register that bit in gnt_idx, set gnt_valid=1, clear cnt, set ptr=winner+1 (7 wraps to 0), go to BUSY.
  - If req=0, stay in IDLE; all outputs stay deasserted.
- BUSY: cnt increments each cycle. The grant ends at the clock edge where any of these holds:
  - done=1: normal release.
  - req[gnt_idx]=0: implicit release; no timeout.
  - cnt==MAX_HOLD-1 and neither of the above: revoke and pulse timeout=1 for one cycle.
  - When the grant ends: gnt_valid←0, gnt←0, state←IDLE. gnt_idx keeps its last value.
- Priority among simultaneous end conditions: done and req-drop take priority over the hold limit. done together with the last hold cycle is a normal release with timeout=0.
- Requests from other clients during BUSY have no effect. There is no preemption.
- After a grant ends, the released client has lowest priority, because ptr already points past it.
- cnt width is $clog2(MAX_HOLD+1). The counter never exceeds MAX_HOLD-1.
- MAX_HOLD=1: every grant lasts exactly one cycle. timeout pulses unless done=1 or the request drops in that cycle.
- gnt is the decoded form of gnt_idx, ANDed with gnt_valid. It is always one-hot or zero.
- Mid-operation reset: outputs clear immediately and asynchronously. ptr returns to 0, so arbitration after reset starts from client 0.

## Timing
- Grant latency:
  - req is sampled at edge k in IDLE.
  - gnt, gnt_idx and gnt_valid are visible in the cycle after edge k.
- Release latency:
  - done, or the req drop, is sampled at edge m.
  - gnt_valid=0 in the cycle after edge m.
  - The earliest next grant is visible after edge m+1.
  - This gives one mandatory dead cycle between consecutive grants.
- Hold limit: a grant is visible for at most MAX_HOLD consecutive cycles. timeout is high in the first cycle after the revoke, aligned with gnt_valid falling.
- All outputs are registered or decoded from registers only; there is no combinational path from inputs to outputs.
- rst_n deassertion is synchronized externally. The block assumes a clean release.

## Structure
- Shared package holds:
  - N_CLIENTS=8 and IDX_W=3.
  - The state enum (IDLE, BUSY).
  - A default for MAX_HOLD.
- Sub-module: instantiate the existing deco_3_8 (in[2:0] → out[7:0]) to decode gnt_idx. AND its output with gnt_valid to drive gnt.
- The rotating priority scan (ptr-relative first-one) is a combinational function inside rr_arb_8, not a separate module.

## Test plan
- Reset and idle:
  - Assert rst_n=0 mid-grant: gnt=0, gnt_valid=0 and timeout=0 immediately.
  - Release reset with req=8'h00: outputs stay 0 indefinitely.
- Single requester:
  - Drive req=8'h08 from reset.
  - gnt=8'h08 and gnt_idx=3 one cycle later.
  - done pulse: gnt=0 next cycle, then gnt=8'h08 again the cycle after.
- Rotation:
  - Hold req=8'hFF and pulse done each grant.
  - Grant order is 0,1,2,…,7,0 with exactly one dead cycle between grants.
- Fairness skip:
  - req=8'h81 from reset: order 0,7,0,7.
  - Set req=8'h22 while ptr=6: next grant is client 1, then client 5.
- Hold limit:
  - MAX_HOLD=4, req=8'h10, done never asserted.
  - gnt=8'h10 for exactly 4 cycles, then gnt=0 with timeout=1 for one cycle, then regrant.
  - Repeat with done asserted in the 4th cycle: timeout stays 0.
- Implicit release:
  - Client 2 holds the grant and drops req[2] without done.
  - gnt=0 next cycle with no timeout; a pending req[5] is granted the cycle after.
